// File: rtl/bambu_mem_pkg.sv
// Shared constants and helpers for the off-chip memory responder.
package bambu_mem_pkg;

  localparam int DEF_READ_DELAY  = 2;
  localparam int DEF_WRITE_DELAY = 1;

  // Byte-lane mask for a write of 'size' bits; caller truncates to its data width.
  function automatic logic [31:0] size_to_mask(input logic [3:0] size);
    return (32'd1 << size) - 32'd1;
  endfunction

  // True when a channel address falls inside [base, base+msize).
  function automatic logic in_window(input int addr, input int base, input int msize);
    return (addr >= base) && (addr < base + msize);
  endfunction

  // Storage index of a channel address relative to the window base.
  function automatic int win_index(input int addr, input int base);
    return addr - base;
  endfunction

endpackage

// File: rtl/bambu_offchip_mem_model_if.sv
// Two-channel master memory bus between the accelerator and the memory responder.
interface bambu_offchip_mem_model_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8,
  parameter int SIZE_W = 4
);
  logic [1:0]          Mout_oe_ram;
  logic [1:0]          Mout_we_ram;
  logic [2*ADDR_W-1:0] Mout_addr_ram;
  logic [2*DATA_W-1:0] Mout_Wdata_ram;
  logic [2*SIZE_W-1:0] Mout_data_ram_size;
  logic [2*DATA_W-1:0] M_Rdata_ram;
  logic [1:0]          M_DataRdy;

  modport master (
    output Mout_oe_ram, Mout_we_ram, Mout_addr_ram, Mout_Wdata_ram, Mout_data_ram_size,
    input  M_Rdata_ram, M_DataRdy
  );

  modport slave (
    input  Mout_oe_ram, Mout_we_ram, Mout_addr_ram, Mout_Wdata_ram, Mout_data_ram_size,
    output M_Rdata_ram, M_DataRdy
  );
endinterface

// File: rtl/bambu_mem_channel_ctrl.sv
// Per-channel latency counter, completion strobe and read-data pipeline.
module bambu_mem_channel_ctrl
  import bambu_mem_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int READ_DELAY  = DEF_READ_DELAY,
  parameter int WRITE_DELAY = DEF_WRITE_DELAY
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              oe_i,
  input  logic              we_i,
  input  logic              in_win_i,
  input  logic [DATA_W-1:0] rd_sample_i,
  output logic              rdy_o,
  output logic [DATA_W-1:0] rdata_o
);

  logic signed [31:0] cnt_q, cnt_d;
  logic [DATA_W-1:0]  pipe_q [READ_DELAY-1];

  // Next counter value: wraps to 0 on the terminal cycle of an access, idles at 0.
  always_comb begin
    cnt_d = '0;
    if (oe_i && in_win_i) begin
      cnt_d = (cnt_q == READ_DELAY - 1) ? 32'sd0 : cnt_q + 32'sd1;
    end else if (we_i && in_win_i) begin
      cnt_d = (cnt_q == WRITE_DELAY - 1) ? 32'sd0 : cnt_q + 32'sd1;
    end
  end

  // Counter register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // Read pipeline samples the storage port every clock; head is the read data.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < READ_DELAY - 1; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= rd_sample_i;
      for (int i = 1; i < READ_DELAY - 1; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  // Strobe is held low while in reset so a held write never reports completion there.
  assign rdy_o = reset && in_win_i && !(oe_i && we_i) &&
                 ((oe_i && (cnt_q == READ_DELAY - 1)) || (we_i && (cnt_q == WRITE_DELAY - 1)));

  assign rdata_o = pipe_q[READ_DELAY-2];

endmodule

// File: rtl/bambu_offchip_mem_model.sv
// Two-channel byte memory responder: storage, write arbitration and error flags.
module bambu_offchip_mem_model
  import bambu_mem_pkg::*;
#(
  parameter int MEMSIZE     = 64,
  parameter int BASE_ADDR   = 0,
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 8,
  parameter int SIZE_W      = 4,
  parameter int READ_DELAY  = DEF_READ_DELAY,
  parameter int WRITE_DELAY = DEF_WRITE_DELAY
) (
  input  logic                      clock,
  input  logic                      reset,
  bambu_offchip_mem_model_if.slave  mem_bus,
  output logic                      err_oe_we,
  output logic                      err_range
);

  localparam int IDX_W = (MEMSIZE > 1) ? $clog2(MEMSIZE) : 1;

  logic [DATA_W-1:0] mem_q [MEMSIZE];
  logic [ADDR_W-1:0] addr [2];
  logic [IDX_W-1:0]  idx [2];
  logic [DATA_W-1:0] wmask [2];
  logic [DATA_W-1:0] wdata [2];
  logic [DATA_W-1:0] rd_sample [2];
  logic [DATA_W-1:0] rdata [2];
  logic [1:0]        in_win, rdy;
  logic [1:0]        oe, we;
  logic              err_oe_we_q, err_range_q;
  int                off [2];
  logic [31:0]       mask32 [2];

  assign oe = mem_bus.Mout_oe_ram;
  assign we = mem_bus.Mout_we_ram;

  // Per-channel decode: window check, storage index, write mask and read port.
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      addr[c]      = mem_bus.Mout_addr_ram[c*ADDR_W +: ADDR_W];
      wdata[c]     = mem_bus.Mout_Wdata_ram[c*DATA_W +: DATA_W];
      in_win[c]    = in_window(int'(addr[c]), BASE_ADDR, MEMSIZE);
      off[c]       = win_index(int'(addr[c]), BASE_ADDR);
      idx[c]       = off[c][IDX_W-1:0];
      mask32[c]    = size_to_mask(mem_bus.Mout_data_ram_size[c*SIZE_W +: 4]);
      wmask[c]     = mask32[c][DATA_W-1:0];
      rd_sample[c] = in_win[c] ? mem_q[idx[c]] : '0;
    end
  end

  // Storage writes; channel 1 is applied last so it wins a same-index collision.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MEMSIZE; i++) mem_q[i] <= '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (we[c] && !oe[c] && in_win[c])
          mem_q[idx[c]] <= (wdata[c] & wmask[c]) | (mem_q[idx[c]] & ~wmask[c]);
      end
    end
  end

  // Sticky protocol error flags, cleared only by reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err_oe_we_q <= 1'b0;
      err_range_q <= 1'b0;
    end else begin
      if (|(oe & we))            err_oe_we_q <= 1'b1;
      if (|((oe | we) & ~in_win)) err_range_q <= 1'b1;
    end
  end

  for (genvar c = 0; c < 2; c++) begin : g_ch
    bambu_mem_channel_ctrl #(
      .DATA_W      (DATA_W),
      .READ_DELAY  (READ_DELAY),
      .WRITE_DELAY (WRITE_DELAY)
    ) u_ctrl (
      .clock       (clock),
      .reset       (reset),
      .oe_i        (oe[c]),
      .we_i        (we[c]),
      .in_win_i    (in_win[c]),
      .rd_sample_i (rd_sample[c]),
      .rdy_o       (rdy[c]),
      .rdata_o     (rdata[c])
    );
  end

  assign mem_bus.M_DataRdy   = rdy;
  assign mem_bus.M_Rdata_ram = {rdata[1], rdata[0]};
  assign err_oe_we           = err_oe_we_q;
  assign err_range           = err_range_q;

endmodule

// File: tb/tb_bambu_offchip_mem_model.sv
// Directed bench for the two-channel memory responder (default latencies plus a READ_DELAY=4 copy).
module tb_bambu_offchip_mem_model;

  typedef struct {
    int         ch;
    bit         wr;
    logic [8:0] addr;
    logic [7:0] wd;
    logic [3:0] sz;
    int         lat;
    logic [7:0] rd;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic reset4 = 1'b0;
  logic err_oe_we, err_range, err_oe_we4, err_range4;

  int chk_cnt = 0;
  int pass_cnt = 0;

  bambu_offchip_mem_model_if #(.ADDR_W(9), .DATA_W(8), .SIZE_W(4)) bus ();
  bambu_offchip_mem_model_if #(.ADDR_W(9), .DATA_W(8), .SIZE_W(4)) bus4 ();

  bambu_offchip_mem_model #(
    .MEMSIZE(64), .BASE_ADDR(0), .ADDR_W(9), .DATA_W(8), .SIZE_W(4),
    .READ_DELAY(2), .WRITE_DELAY(1)
  ) dut (
    .clock(clock), .reset(reset), .mem_bus(bus),
    .err_oe_we(err_oe_we), .err_range(err_range)
  );

  bambu_offchip_mem_model #(
    .MEMSIZE(64), .BASE_ADDR(0), .ADDR_W(9), .DATA_W(8), .SIZE_W(4),
    .READ_DELAY(4), .WRITE_DELAY(1)
  ) dut4 (
    .clock(clock), .reset(reset4), .mem_bus(bus4),
    .err_oe_we(err_oe_we4), .err_range(err_range4)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached (got timeout, required completion)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  task automatic set_req(input int ch, input logic oe, input logic we, input logic [8:0] addr,
                         input logic [7:0] wd, input logic [3:0] sz);
    bus.Mout_oe_ram[ch]               = oe;
    bus.Mout_we_ram[ch]               = we;
    bus.Mout_addr_ram[ch*9 +: 9]      = addr;
    bus.Mout_Wdata_ram[ch*8 +: 8]     = wd;
    bus.Mout_data_ram_size[ch*4 +: 4] = sz;
  endtask

  // One transaction held until DataRdy (bounded), then dropped on the next cycle.
  task automatic do_txn(input string name, input int ch, input bit wr, input logic [8:0] addr,
                        input logic [7:0] wd, input logic [3:0] sz, input int exp_lat,
                        input logic [7:0] exp_rd);
    int lat;
    lat = -1;
    set_req(ch, !wr, wr, addr, wd, sz);
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clock);
      if (bus.M_DataRdy[ch]) begin
        lat = cyc;
        if (!wr) check({name, " rdata"}, 32'(bus.M_Rdata_ram[ch*8 +: 8]), 32'(exp_rd));
        break;
      end
      @(posedge clock); #1;
    end
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    if (lat >= 0) begin
      @(posedge clock); #1;
    end
    set_req(ch, 1'b0, 1'b0, addr, 8'h00, 4'd0);
  endtask

  vec_t vecs [12];
  bit   seen;

  initial begin
    vecs[0]  = '{0, 1'b0, 9'h005, 8'h00, 4'd8,  1, 8'h00};
    vecs[1]  = '{1, 1'b1, 9'h00A, 8'hA5, 4'd8,  0, 8'h00};
    vecs[2]  = '{0, 1'b0, 9'h00A, 8'h00, 4'd8,  1, 8'hA5};
    vecs[3]  = '{0, 1'b1, 9'h003, 8'hFF, 4'd8,  0, 8'h00};
    vecs[4]  = '{1, 1'b1, 9'h003, 8'h12, 4'd4,  0, 8'h00};
    vecs[5]  = '{1, 1'b0, 9'h003, 8'h00, 4'd8,  1, 8'hF2};
    vecs[6]  = '{0, 1'b1, 9'h03F, 8'h5A, 4'd8,  0, 8'h00};
    vecs[7]  = '{1, 1'b0, 9'h03F, 8'h00, 4'd8,  1, 8'h5A};
    vecs[8]  = '{1, 1'b1, 9'h000, 8'hC3, 4'd2,  0, 8'h00};
    vecs[9]  = '{0, 1'b0, 9'h000, 8'h00, 4'd8,  1, 8'h03};
    vecs[10] = '{0, 1'b1, 9'h00A, 8'h00, 4'd0,  0, 8'h00};
    vecs[11] = '{0, 1'b0, 9'h00A, 8'h00, 4'd8,  1, 8'hA5};

    bus.Mout_oe_ram = '0; bus.Mout_we_ram = '0; bus.Mout_addr_ram = '0;
    bus.Mout_Wdata_ram = '0; bus.Mout_data_ram_size = '0;
    bus4.Mout_oe_ram = '0; bus4.Mout_we_ram = '0; bus4.Mout_addr_ram = '0;
    bus4.Mout_Wdata_ram = '0; bus4.Mout_data_ram_size = '0;

    // Reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset DataRdy", 32'(bus.M_DataRdy), 32'd0);
    check("reset Rdata", 32'(bus.M_Rdata_ram), 32'd0);
    check("reset errors", 32'({err_oe_we, err_range}), 32'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    reset4 = 1'b1;
    @(posedge clock); #1;

    for (int i = 0; i < 12; i++)
      do_txn($sformatf("vec%0d", i), vecs[i].ch, vecs[i].wr, vecs[i].addr, vecs[i].wd,
             vecs[i].sz, vecs[i].lat, vecs[i].rd);
    @(negedge clock);
    check("errors after legal traffic", 32'({err_oe_we, err_range}), 32'd0);
    @(posedge clock); #1;

    // Same-index write collision: channel 1 wins
    set_req(0, 1'b0, 1'b1, 9'h010, 8'h11, 4'd8);
    set_req(1, 1'b0, 1'b1, 9'h010, 8'h22, 4'd8);
    @(negedge clock);
    check("dual write DataRdy", 32'(bus.M_DataRdy), 32'd3);
    @(posedge clock); #1;
    set_req(0, 1'b0, 1'b0, 9'h010, 8'h00, 4'd0);
    set_req(1, 1'b0, 1'b0, 9'h010, 8'h00, 4'd0);
    do_txn("collision read", 0, 1'b0, 9'h010, 8'h00, 4'd8, 1, 8'h22);

    // Read and write to one index in the same cycle: read sees old value
    set_req(0, 1'b1, 1'b0, 9'h020, 8'h00, 4'd8);
    set_req(1, 1'b0, 1'b1, 9'h020, 8'h99, 4'd8);
    @(negedge clock);
    check("rw same cycle DataRdy", 32'(bus.M_DataRdy), 32'd2);
    @(posedge clock); #1;
    set_req(1, 1'b0, 1'b0, 9'h020, 8'h00, 4'd0);
    @(negedge clock);
    check("rw same cycle read rdy", 32'(bus.M_DataRdy[0]), 32'd1);
    check("rw same cycle old data", 32'(bus.M_Rdata_ram[7:0]), 32'h00);
    @(posedge clock); #1;
    set_req(0, 1'b0, 1'b0, 9'h020, 8'h00, 4'd0);
    do_txn("rw followup read", 0, 1'b0, 9'h020, 8'h00, 4'd8, 1, 8'h99);

    // Out-of-window read
    set_req(0, 1'b1, 1'b0, 9'h100, 8'h00, 4'd8);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clock);
      seen = seen | bus.M_DataRdy[0];
      @(posedge clock); #1;
    end
    @(negedge clock);
    check("oow DataRdy never", 32'(seen), 32'd0);
    check("oow Rdata zero", 32'(bus.M_Rdata_ram[7:0]), 32'd0);
    check("oow err_range", 32'(err_range), 32'd1);
    check("oow err_oe_we clear", 32'(err_oe_we), 32'd0);
    @(posedge clock); #1;
    set_req(0, 1'b0, 1'b0, 9'h000, 8'h00, 4'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("err_range sticky", 32'(err_range), 32'd1);
    @(posedge clock); #1;

    // oe and we together on one channel
    set_req(1, 1'b1, 1'b1, 9'h00A, 8'h00, 4'd8);
    seen = 1'b0;
    repeat (3) begin
      @(negedge clock);
      seen = seen | bus.M_DataRdy[1];
      @(posedge clock); #1;
    end
    set_req(1, 1'b0, 1'b0, 9'h00A, 8'h00, 4'd0);
    @(negedge clock);
    check("oe_we DataRdy never", 32'(seen), 32'd0);
    check("oe_we flag", 32'(err_oe_we), 32'd1);
    @(posedge clock); #1;
    do_txn("oe_we mem unchanged", 1, 1'b0, 9'h00A, 8'h00, 4'd8, 1, 8'hA5);

    // Reset clears flags and storage
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("reset clears errors", 32'({err_oe_we, err_range}), 32'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    do_txn("storage cleared", 0, 1'b0, 9'h00A, 8'h00, 4'd8, 1, 8'h00);

    // READ_DELAY=4 copy: reset in the middle of a read
    bus4.Mout_we_ram[0] = 1'b1;
    bus4.Mout_addr_ram[8:0] = 9'h001;
    bus4.Mout_Wdata_ram[7:0] = 8'h5C;
    bus4.Mout_data_ram_size[3:0] = 4'd8;
    @(negedge clock);
    check("d4 write rdy", 32'(bus4.M_DataRdy[0]), 32'd1);
    @(posedge clock); #1;
    bus4.Mout_we_ram[0] = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    @(negedge clock);
    check("d4 pipeline filled", 32'(bus4.M_Rdata_ram[7:0]), 32'h5C);
    @(posedge clock); #1;
    bus4.Mout_oe_ram[0] = 1'b1;
    seen = 1'b0;
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clock);
      seen = seen | bus4.M_DataRdy[0];
      if (cyc < 2) begin
        @(posedge clock); #1;
      end
    end
    check("d4 no early rdy", 32'(seen), 32'd0);
    #2;
    reset4 = 1'b0;
    #1;
    check("d4 reset rdy", 32'(bus4.M_DataRdy), 32'd0);
    check("d4 reset rdata", 32'(bus4.M_Rdata_ram), 32'd0);
    check("d4 reset errors", 32'({err_oe_we4, err_range4}), 32'd0);
    bus4.Mout_oe_ram[0] = 1'b0;
    @(posedge clock); #1;
    reset4 = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clock);
      seen = seen | (|bus4.M_DataRdy);
    end
    check("d4 aborted read no rdy", 32'(seen), 32'd0);
    @(posedge clock); #1;
    bus4.Mout_oe_ram[0] = 1'b1;
    begin
      int lat;
      lat = -1;
      for (int cyc = 0; cyc < 8; cyc++) begin
        @(negedge clock);
        if (bus4.M_DataRdy[0]) begin
          lat = cyc;
          check("d4 read after reset data", 32'(bus4.M_Rdata_ram[7:0]), 32'h00);
          break;
        end
        @(posedge clock); #1;
      end
      check("d4 read latency", 32'(lat), 32'd3);
    end
    @(posedge clock); #1;
    bus4.Mout_oe_ram[0] = 1'b0;
    @(posedge clock);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
